// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and MMU-side bus signals seen by the OAM DMA arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface oam_dma_arbiter_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_rd_enable;
    logic        cpu_wr_enable;
    logic [7:0]  cpu_data_in;

    logic [15:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic        mem_rd_enable;
    logic        mem_wr_enable;
    logic [7:0]  mem_data_in;

    modport master (
        output cpu_addr, cpu_data_out, cpu_rd_enable, cpu_wr_enable, mem_data_in,
        input  cpu_data_in, mem_addr, mem_data_out, mem_rd_enable, mem_wr_enable
    );

    modport slave (
        input  cpu_addr, cpu_data_out, cpu_rd_enable, cpu_wr_enable, mem_data_in,
        output cpu_data_in, mem_addr, mem_data_out, mem_rd_enable, mem_wr_enable
    );
endinterface

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine: copies LENGTH bytes from {page,8'h00} to OAM_BASE while arbitrating
// the single MMU port between the copy and the CPU (HRAM and the DMA register win).
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG  = 16'hFF46,
    parameter logic [15:0] OAM_BASE = 16'hFE00,
    parameter int unsigned LENGTH   = 160,
    parameter logic [15:0] HRAM_LO  = 16'hFF80,
    parameter logic [15:0] HRAM_HI  = 16'hFFFE
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    oam_dma_arbiter_if.slave      bus,
    output logic                  o_dma_active
);

    localparam logic [7:0] LastIdx = 8'(LENGTH - 1);

    typedef enum logic [1:0] {StIdle, StStart, StRead, StWrite} state_e;

    state_e     r_state, w_state_next;
    logic [7:0] r_src, w_src_next;
    logic [7:0] r_idx, w_idx_next;
    logic [7:0] r_latch, w_latch_next;

    logic       w_reg_hit;
    logic       w_reg_wr;
    logic       w_hram;
    logic       w_active;
    logic       w_stall;
    logic       w_dma_drive;
    logic [7:0] w_page;

    always_comb begin
        w_reg_hit   = (bus.cpu_addr == DMA_REG);
        w_reg_wr    = w_reg_hit && bus.cpu_wr_enable;
        w_hram      = (bus.cpu_rd_enable || bus.cpu_wr_enable) &&
                      (bus.cpu_addr >= HRAM_LO) && (bus.cpu_addr <= HRAM_HI);
        w_active    = (r_state != StIdle);
        w_stall     = w_active && w_hram;
        // A restart abandons the byte in flight; reset kills it in the same cycle.
        w_dma_drive = w_active && !w_stall && !w_reg_wr && !i_rst;
        // Echo region E0-FF reads from C0-DF.
        w_page      = (r_src >= 8'hE0) ? (r_src & 8'hDF) : r_src;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_src   <= 8'hFF;
            r_idx   <= 8'h00;
            r_latch <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_src   <= w_src_next;
            r_idx   <= w_idx_next;
            r_latch <= w_latch_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_src_next   = r_src;
        w_idx_next   = r_idx;
        w_latch_next = r_latch;
        if (w_reg_wr) begin
            w_src_next   = bus.cpu_data_out;
            w_state_next = StStart;
            w_idx_next   = 8'h00;
        end else if (!w_stall) begin
            unique case (r_state)
                StIdle: ;
                StStart: begin
                    w_state_next = StRead;
                    w_idx_next   = 8'h00;
                end
                StRead: begin
                    w_latch_next = bus.mem_data_in;
                    w_state_next = StWrite;
                end
                StWrite: begin
                    if (r_idx == LastIdx) begin
                        w_state_next = StIdle;
                        w_idx_next   = 8'h00;
                    end else begin
                        w_state_next = StRead;
                        w_idx_next   = r_idx + 8'd1;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        bus.mem_addr      = bus.cpu_addr;
        bus.mem_data_out  = bus.cpu_data_out;
        bus.mem_rd_enable = 1'b0;
        bus.mem_wr_enable = 1'b0;
        bus.cpu_data_in   = bus.mem_data_in;

        if (w_reg_hit) begin
            bus.cpu_data_in = r_src;
        end else if (!w_active || w_hram) begin
            bus.mem_rd_enable = bus.cpu_rd_enable;
            bus.mem_wr_enable = bus.cpu_wr_enable;
        end else if (bus.cpu_rd_enable) begin
            bus.cpu_data_in = 8'hFF;
        end

        if (w_dma_drive) begin
            unique case (r_state)
                StRead: begin
                    bus.mem_addr      = {w_page, r_idx};
                    bus.mem_rd_enable = 1'b1;
                end
                StWrite: begin
                    bus.mem_addr      = OAM_BASE + {8'h00, r_idx};
                    bus.mem_data_out  = r_latch;
                    bus.mem_wr_enable = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_dma_active = w_active;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: a per-cycle scoreboard fed by an abstract countdown model
// of the copy, plus a memory stub acting as the MMU and end-of-test image checks.
module tb_oam_dma_arbiter;

    localparam int TotalCycles = 1 + 2 * 160;

    logic clk = 1'b0;
    logic rst;
    logic dma_active;

    always #5 clk = ~clk;

    oam_dma_arbiter_if bus ();

    oam_dma_arbiter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (bus),
        .o_dma_active (dma_active)
    );

    typedef struct {
        logic        act;
        logic        wr_v;
        logic [15:0] wr_a;
        logic [7:0]  wr_d;
        logic        rd_v;
        logic [7:0]  rd_d;
        logic        rd_blk;
        logic [15:0] cpu_a;
    } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad = 0;

    logic [7:0] dut_mem [65536];
    logic [7:0] ref_mem [65536];
    int         m_left;
    logic [7:0] m_src;
    logic [7:0] m_page;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        if (a >= 16'hC000 && a < 16'hC0A0) return a[7:0] ^ 8'h5A;
        return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // MMU stub: combinational read, write at the clock edge.
    assign bus.mem_data_in = dut_mem[bus.mem_addr];
    initial begin
        for (int i = 0; i < 65536; i++) dut_mem[i] <= init_byte(16'(i));
        forever begin
            @(posedge clk);
            if (bus.mem_wr_enable === 1'b1) dut_mem[bus.mem_addr] <= bus.mem_data_out;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("dma_active", 32'(dma_active), 32'(e.act));
                if (e.wr_v || bus.mem_wr_enable !== 1'b0) begin
                    chk("mem_wr_enable", 32'(bus.mem_wr_enable), 32'(e.wr_v));
                    if (e.wr_v) begin
                        chk("mem_wr_addr", 32'(bus.mem_addr), 32'(e.wr_a));
                        chk("mem_wr_data", 32'(bus.mem_data_out), 32'(e.wr_d));
                    end
                end
                if (e.rd_v) begin
                    chk("cpu_data_in", 32'(bus.cpu_data_in), 32'(e.rd_d));
                    if (e.rd_blk)
                        chk("blocked_rd_strobe",
                            32'(bus.mem_rd_enable && bus.mem_addr == e.cpu_a), 32'd0);
                end
            end
        end
    end

    // One bus cycle: drive CPU inputs, predict the DUT response, advance the model.
    task automatic cyc(input logic r, input logic w, input logic [15:0] a,
                       input logic [7:0] d, input logic rs);
        exp_t e;
        logic act, hit, hram, adv;
        int   p, i;
        bus.cpu_rd_enable = r;
        bus.cpu_wr_enable = w;
        bus.cpu_addr      = a;
        bus.cpu_data_out  = d;
        rst               = rs;

        act  = (m_left > 0);
        hit  = (a == 16'hFF46);
        hram = (r || w) && a >= 16'hFF80 && a <= 16'hFFFE;
        e    = '{default: '0};
        e.act   = act;
        e.cpu_a = a;
        if (r) begin
            e.rd_v = 1'b1;
            if (hit) e.rd_d = m_src;
            else if (!act || hram) e.rd_d = ref_mem[a];
            else begin
                e.rd_d   = 8'hFF;
                e.rd_blk = 1'b1;
            end
        end
        if (w && !hit && (!act || hram)) begin
            e.wr_v = 1'b1;
            e.wr_a = a;
            e.wr_d = d;
        end
        adv = act && !hram && !(hit && w) && !rs;
        if (adv) begin
            p = TotalCycles - m_left;
            if (p >= 2 && p % 2 == 0) begin
                i      = (p - 2) / 2;
                e.wr_v = 1'b1;
                e.wr_a = 16'hFE00 + 16'(i);
                e.wr_d = ref_mem[{m_page, 8'(i)}];
            end
        end
        sb_q.push_back(e);

        if (e.wr_v) ref_mem[e.wr_a] = e.wr_d;
        if (rs) begin
            m_left = 0;
            m_src  = 8'hFF;
        end else if (hit && w) begin
            m_src  = d;
            m_page = (d >= 8'hE0) ? d - 8'h20 : d;
            m_left = TotalCycles;
        end else if (adv) begin
            m_left--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    endtask

    task automatic run_done();
        for (int k = 0; k < 2000 && m_left > 0; k++) idle(1);
        idle(3);
    endtask

    task automatic random_traffic();
        int unsigned sel;
        for (int k = 0; k < 2000 && m_left > 0; k++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                5: cyc(1'b0, 1'b1, 16'(16'hFF80 + $urandom_range(0, 126)),
                       8'($urandom), 1'b0);
                6: cyc(1'b1, 1'b0, 16'(16'hFF80 + $urandom_range(0, 126)), 8'h00, 1'b0);
                7: cyc(1'b1, 1'b0, 16'($urandom_range(0, 16'hFDFF)), 8'h00, 1'b0);
                8: cyc(1'b0, 1'b1, 16'($urandom_range(0, 16'hFDFF)), 8'($urandom), 1'b0);
                default: idle(1);
            endcase
        end
        idle(3);
    endtask

    task automatic check_image(input string name);
        int nmis = 0;
        for (int i = 0; i < 65536; i++) if (dut_mem[i] !== ref_mem[i]) nmis++;
        chk(name, 32'(nmis), 32'd0);
    endtask

    task automatic check_oam(input string name, input logic [7:0] page_lo,
                             input logic [7:0] page_hi, input int split);
        int nmis = 0;
        logic [7:0] want;
        for (int i = 0; i < 160; i++) begin
            want = (i < split) ? init_byte({page_lo, 8'(i)}) : init_byte({page_hi, 8'(i)});
            if (dut_mem[16'hFE00 + 16'(i)] !== want) nmis++;
        end
        chk(name, 32'(nmis), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
        m_left = 0;
        m_src  = 8'hFF;
        m_page = 8'hFF;
        bus.cpu_rd_enable = 1'b0;
        bus.cpu_wr_enable = 1'b0;
        bus.cpu_addr      = 16'h0000;
        bus.cpu_data_out  = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and idle pass-through.
        cyc(1'b1, 1'b0, 16'hFF46, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 16'h9000, 8'h11, 1'b0);
        cyc(1'b1, 1'b0, 16'h9000, 8'h00, 1'b0);

        // Basic copy from C000.
        cyc(1'b0, 1'b1, 16'hFF46, 8'hC0, 1'b0);
        run_done();
        check_oam("basic_copy_oam", 8'hC0, 8'hC0, 160);

        // Echo page E1 -> C1, with directed blocking and random CPU traffic.
        cyc(1'b0, 1'b1, 16'hFF46, 8'hE1, 1'b0);
        idle(3);
        cyc(1'b1, 1'b0, 16'h8000, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 16'hD000, 8'h77, 1'b0);
        random_traffic();
        check_oam("echo_copy_oam", 8'hC1, 8'hC1, 160);
        chk("blocked_write_d000", 32'(dut_mem[16'hD000]), 32'(init_byte(16'hD000)));
        check_image("echo_image");

        // HRAM priority: five stalling writes.
        cyc(1'b0, 1'b1, 16'hFF46, 8'hC0, 1'b0);
        idle(20);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, 16'hFF90, 8'h3C, 1'b0);
            idle(7);
        end
        run_done();
        cyc(1'b1, 1'b0, 16'hFF90, 8'h00, 1'b0);
        chk("hram_ff90", 32'(dut_mem[16'hFF90]), 32'h3C);
        check_oam("hram_copy_oam", 8'hC0, 8'hC0, 160);

        // Restart at idx 50 with page D0.
        cyc(1'b0, 1'b1, 16'hFF46, 8'hC0, 1'b0);
        idle(101);
        cyc(1'b0, 1'b1, 16'hFF46, 8'hD0, 1'b0);
        run_done();
        check_oam("restart_oam", 8'hD0, 8'hD0, 160);
        check_image("restart_image");

        // Reset at idx 80: bytes 0..79 from C0, the rest keep the D0 copy.
        cyc(1'b0, 1'b1, 16'hFF46, 8'hC0, 1'b0);
        idle(161);
        cyc(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        cyc(1'b1, 1'b0, 16'hFF46, 8'h00, 1'b0);
        idle(5);
        check_oam("reset_mid_oam", 8'hC0, 8'hD0, 80);
        check_image("reset_image");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oam_dma_arbiter.md
# oam_dma_arbiter

Sits between the CPU bus and the MMU and owns the OAM DMA register. A CPU write to the DMA register starts a 160-byte copy from `{src,8'h00}` into OAM at `FE00`. While the copy runs, the block arbitrates the single MMU port between the DMA engine and the CPU:

- CPU access to HRAM and to the DMA register wins the bus.
- All other CPU traffic is blocked.

## Interface

**Parameters**

- `DMA_REG`, 16'hFF46: address of the DMA source register.
- `OAM_BASE`, 16'hFE00: destination base address.
- `LENGTH`, 160: bytes per transfer; must be ≤ 256.
- `HRAM_LO`, 16'hFF80: first HRAM address.
- `HRAM_HI`, 16'hFFFE: last HRAM address.

**Ports**

- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset.
- `cpu_addr` in 16: CPU address.
- `cpu_data_out` in 8: CPU write data.
- `cpu_rd_enable` in 1: CPU read strobe.
- `cpu_wr_enable` in 1: CPU write strobe.
- `cpu_data_in` out 8: read data returned to the CPU.
- `mem_addr` out 16: MMU address.
- `mem_data_out` out 8: MMU write data.
- `mem_rd_enable` out 1: MMU read strobe.
- `mem_wr_enable` out 1: MMU write strobe.
- `mem_data_in` in 8: MMU read data, combinational, valid in the same cycle.
- `dma_active` out 1: high while a transfer is in progress.

## Operation

**Registers**

- `src_reg` (8): DMA source page. Reset value 8'hFF.
- `idx` (8): byte index.
- `latch` (8): holds the byte read in the previous phase.
- `state`: IDLE, START, READ, WRITE.

**DMA register access**

- A CPU write with `cpu_addr==DMA_REG` loads `src_reg` at the clock edge. It is never forwarded to the MMU.
- A CPU read of `DMA_REG` returns `src_reg` combinationally. No MMU strobe is raised.

**Source address**

- Effective source page = `src_reg` with bit 5 cleared when `src_reg>=8'hE0`. This maps E0–FF to C0–DF.

**State machine**

- IDLE → START on a DMA_REG write.
- START (1 cycle) → READ, with `idx=0`.
- READ:
  - Drives `mem_addr={page,idx}` and `mem_rd_enable=1`.
  - Captures `mem_data_in` into `latch`, then → WRITE.
- WRITE:
  - Drives `mem_addr=OAM_BASE+idx`, `mem_data_out=latch`, `mem_wr_enable=1`.
  - Then `idx+1` → READ, or → IDLE when `idx==LENGTH-1`.
- `dma_active` = state≠IDLE.

**Arbitration while `dma_active`**

- **CPU HRAM access** (address in [HRAM_LO,HRAM_HI] with rd or wr high):
  - The CPU access passes to the MMU unchanged.
  - The DMA phase stalls that cycle: state, `idx` and `latch` are held.
  - START also holds.
- **CPU DMA_REG write:** restarts the transfer. State → START and the new `src_reg` is used. The byte in flight is abandoned, with no write to OAM.
- **Other CPU reads:** `cpu_data_in=8'hFF`, not forwarded.
- **Other CPU writes:** dropped.
- In both of the last two cases the DMA phase proceeds.

**Pass-through when IDLE**

- All CPU signals except DMA_REG access map straight onto the `mem_*` ports.
- `cpu_data_in=mem_data_in`.

**Idle bus**

- With no CPU request and no DMA phase, `mem_rd_enable=mem_wr_enable=0`, `mem_addr=cpu_addr` and `mem_data_out=cpu_data_out`.

**`cpu_data_in`**

- Defaults to `mem_data_in` whenever the CPU access was forwarded.

## Timing

**Reset**

- Applies at a rising edge with `rst=1`.
- Results: state=IDLE, `idx=0`, `latch=0`, `src_reg=8'hFF`, `dma_active=0`.
- Reset mid-transfer aborts immediately. No further OAM writes occur.

**Latency**

- A DMA_REG write sampled at edge N gives START during cycle N+1 and the first READ in cycle N+2.
- The last WRITE is in cycle N+1+2·LENGTH; with LENGTH=160 that is N+321.
- `dma_active` falls after edge N+322.
- Each stall cycle adds one cycle.

**Boundary conditions**

- `idx` never wraps: LENGTH≤256 and termination is on `idx==LENGTH-1`.
- If a DMA_REG write and an HRAM access would coincide, the register write wins. The CPU cannot issue both in the same cycle.
- All `mem_*` outputs and `cpu_data_in` are combinational from state and CPU inputs. There is no output register.

## Test plan

- **Basic copy:** preload C000–C09F with `i^8'h5A`, write 8'hC0 to FF46 → FE00–FE9F hold the same bytes. `dma_active` is high for exactly 321 cycles after the write edge.
- **Echo mapping:** write 8'hE1 to FF46 → the source is read from C100–C19F.
- **Bus blocking:** during DMA the CPU reads 0x8000 → 8'hFF with no `mem_rd_enable` for it. A CPU write to D000 leaves memory unchanged.
- **HRAM priority:** during DMA the CPU writes FF90=8'h3C on 5 cycles → FF90 reads back 8'h3C, the transfer finishes 5 cycles later, and OAM contents are intact.
- **Restart:** write 8'hC0, then 8'hD0 at `idx=50` → FE00–FE9F end holding D000–D09F data. Completion is 321 cycles after the second write.
- **Reset mid-transfer:** assert `rst` at `idx=80` → `dma_active=0` on the next cycle, FE50 onward unchanged, and FF46 reads 8'hFF.
